// File: rtl/cfd_cfg_receiver.sv
// Configuration receiver for the 16-channel CFD front end: parallel or
// serial commands committed on STB, per-channel DAC codes and enables, serial readback.
module cfd_cfg_receiver #(
    parameter int CHANNELS = 16,
    parameter int ADDRBITS = 4,
    parameter int DATABITS = 6,
    parameter int MODEBITS = 4,
    parameter int DAC_RST  = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [ADDRBITS-1:0]          ADDR,
    input  logic [DATABITS-1:0]          DATA,
    input  logic [MODEBITS-1:0]          MODE,
    input  logic                         STB,
    input  logic                         SI,
    input  logic                         SI_CLK,
    input  logic                         SO_CLK,
    output logic                         SO,
    output logic [CHANNELS*DATABITS-1:0] DAC,
    output logic [CHANNELS-1:0]          EN,
    output logic                         DONE,
    output logic                         ERR
);

    localparam int FLEN  = MODEBITS + ADDRBITS + DATABITS;
    localparam int RBLEN = ADDRBITS + DATABITS + 1;
    localparam int CW    = $clog2(FLEN + 2);

    localparam logic [MODEBITS-1:0] M_NOP   = MODEBITS'(0);
    localparam logic [MODEBITS-1:0] M_WR    = MODEBITS'(1);
    localparam logic [MODEBITS-1:0] M_BCAST = MODEBITS'(2);
    localparam logic [MODEBITS-1:0] M_EN    = MODEBITS'(3);
    localparam logic [MODEBITS-1:0] M_RB    = MODEBITS'(4);
    localparam logic [MODEBITS-1:0] M_SRST  = MODEBITS'(15);

    localparam logic [CW-1:0] CNT_FULL = CW'(FLEN);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FLEN + 1);

    logic [2:0] stb_q;
    logic [2:0] sic_q;
    logic [2:0] soc_q;
    logic [1:0] si_q;

    logic stb_rise;
    logic sic_rise;
    logic so_rise;

    logic [FLEN-1:0]     shreg;
    logic [CW-1:0]       cnt;
    logic [RBLEN-1:0]    rb;
    logic [DATABITS-1:0] dac_r [CHANNELS];
    logic [CHANNELS-1:0] en_r;
    logic                done_r;
    logic                err_r;

    logic                cmd_go;
    logic                cnt_err;
    logic [MODEBITS-1:0] cmd_mode;
    logic [ADDRBITS-1:0] cmd_addr;
    logic [DATABITS-1:0] cmd_data;
    logic                addr_ok;
    logic [DATABITS-1:0] dac_sel;
    logic                en_sel;

    // Synchronizers are deliberately left untouched by soft reset so a
    // still-high STB cannot be mistaken for a fresh rising edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stb_q <= '0;
            sic_q <= '0;
            soc_q <= '0;
            si_q  <= '0;
        end else begin
            stb_q <= {stb_q[1:0], STB};
            sic_q <= {sic_q[1:0], SI_CLK};
            soc_q <= {soc_q[1:0], SO_CLK};
            si_q  <= {si_q[0], SI};
        end
    end

    assign stb_rise = stb_q[1] & ~stb_q[2];
    assign sic_rise = sic_q[1] & ~sic_q[2];
    assign so_rise  = soc_q[1] & ~soc_q[2];

    always_comb begin
        cmd_go   = 1'b0;
        cnt_err  = 1'b0;
        cmd_mode = MODE;
        cmd_addr = ADDR;
        cmd_data = DATA;
        if (stb_rise) begin
            if (cnt == '0) begin
                cmd_go = 1'b1;
            end else if (cnt == CNT_FULL) begin
                cmd_go   = 1'b1;
                cmd_mode = shreg[FLEN-1 -: MODEBITS];
                cmd_addr = shreg[DATABITS +: ADDRBITS];
                cmd_data = shreg[DATABITS-1:0];
            end else begin
                cnt_err = 1'b1;
            end
        end
    end

    always_comb begin
        addr_ok = int'(cmd_addr) < CHANNELS;
        dac_sel = '0;
        en_sel  = 1'b0;
        if (addr_ok) begin
            dac_sel = dac_r[cmd_addr];
            en_sel  = en_r[cmd_addr];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg  <= '0;
            cnt    <= '0;
            rb     <= '0;
            en_r   <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) dac_r[i] <= DATABITS'(DAC_RST);
        end else begin
            done_r <= 1'b0;

            // A commit owns the frame; a coincident serial shift is dropped.
            if (stb_rise) begin
                cnt <= '0;
            end else if (sic_rise) begin
                shreg <= {shreg[FLEN-2:0], si_q[1]};
                if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
            end

            if (so_rise) rb <= {rb[RBLEN-2:0], 1'b0};

            if (cnt_err) err_r <= 1'b1;

            if (cmd_go) begin
                case (cmd_mode)
                    M_NOP: begin
                        done_r <= 1'b1;
                    end
                    M_WR: begin
                        if (addr_ok) dac_r[cmd_addr] <= cmd_data;
                        done_r <= 1'b1;
                    end
                    M_BCAST: begin
                        for (int i = 0; i < CHANNELS; i++) dac_r[i] <= cmd_data;
                        done_r <= 1'b1;
                    end
                    M_EN: begin
                        if (addr_ok) en_r[cmd_addr] <= cmd_data[0];
                        done_r <= 1'b1;
                    end
                    M_RB: begin
                        rb     <= {cmd_addr, dac_sel, en_sel};
                        done_r <= 1'b1;
                    end
                    M_SRST: begin
                        shreg  <= '0;
                        cnt    <= '0;
                        rb     <= '0;
                        en_r   <= '0;
                        err_r  <= 1'b0;
                        done_r <= 1'b1;
                        for (int i = 0; i < CHANNELS; i++) dac_r[i] <= DATABITS'(DAC_RST);
                    end
                    default: begin
                        err_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_dac
        assign DAC[g*DATABITS +: DATABITS] = dac_r[g];
    end

    assign SO   = rb[RBLEN-1];
    assign EN   = en_r;
    assign DONE = done_r;
    assign ERR  = err_r;

endmodule

// File: tb/tb_cfd_cfg_receiver.sv
// Directed bench for cfd_cfg_receiver: vector table of parallel commands
// plus hand-written serial, readback, error and reset sequences.
module tb_cfd_cfg_receiver;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  ADDR = '0;
    logic [5:0]  DATA = '0;
    logic [3:0]  MODE = '0;
    logic        STB = 1'b0;
    logic        SI = 1'b0;
    logic        SI_CLK = 1'b0;
    logic        SO_CLK = 1'b0;
    logic        SO;
    logic [95:0] DAC;
    logic [15:0] EN;
    logic        DONE;
    logic        ERR;

    int errors = 0;
    int checks = 0;
    int done_seen;
    int done_first;

    cfd_cfg_receiver dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA(DATA), .MODE(MODE),
        .STB(STB), .SI(SI), .SI_CLK(SI_CLK), .SO_CLK(SO_CLK),
        .SO(SO), .DAC(DAC), .EN(EN), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [3:0]  mode;
        logic [3:0]  addr;
        logic [5:0]  data;
        logic [95:0] exp_dac;
        logic [15:0] exp_en;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [95:0] rep(input logic [5:0] v);
        logic [95:0] r;
        for (int i = 0; i < 16; i++) r[i*6 +: 6] = v;
        return r;
    endfunction

    function automatic logic [95:0] with_ch(input logic [95:0] b,
                                            input int ch, input logic [5:0] v);
        logic [95:0] r;
        r = b;
        r[ch*6 +: 6] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic watch(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge CLK);
            if (i == 4) STB = 1'b0;
            if (DONE) begin
                done_seen++;
                if (done_first == 0) done_first = i;
            end
        end
    endtask

    task automatic strobe();
        done_seen  = 0;
        done_first = 0;
        @(negedge CLK);
        STB = 1'b1;
        watch(8);
    endtask

    task automatic par_cmd(input logic [3:0] m, input logic [3:0] a,
                           input logic [5:0] d);
        MODE = m;
        ADDR = a;
        DATA = d;
        strobe();
    endtask

    task automatic send_bits(input logic [15:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge CLK);
            SI = f[i];
            repeat (2) @(negedge CLK);
            SI_CLK = 1'b1;
            repeat (4) @(negedge CLK);
            SI_CLK = 1'b0;
            repeat (3) @(negedge CLK);
        end
    endtask

    task automatic so_pulse();
        @(negedge CLK);
        SO_CLK = 1'b1;
        repeat (4) @(negedge CLK);
        SO_CLK = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    logic [10:0] rbx;
    logic        so_exp;
    logic [95:0] d32;

    initial begin
        d32 = rep(6'd32);
        vecs[0] = '{"wr_ch5",   4'h1, 4'd5,  6'h2A, with_ch(d32, 5, 6'h2A), 16'h0000, 1, 1'b0};
        vecs[1] = '{"en_ch2",   4'h3, 4'd2,  6'h01, with_ch(d32, 5, 6'h2A), 16'h0004, 1, 1'b0};
        vecs[2] = '{"wr_ch15",  4'h1, 4'd15, 6'h3F,
                    with_ch(with_ch(d32, 5, 6'h2A), 15, 6'h3F), 16'h0004, 1, 1'b0};
        vecs[3] = '{"nop",      4'h0, 4'd7,  6'h11,
                    with_ch(with_ch(d32, 5, 6'h2A), 15, 6'h3F), 16'h0004, 1, 1'b0};
        vecs[4] = '{"dis_ch2",  4'h3, 4'd2,  6'h3E,
                    with_ch(with_ch(d32, 5, 6'h2A), 15, 6'h3F), 16'h0000, 1, 1'b0};
        vecs[5] = '{"bcast7",   4'h2, 4'd0,  6'h07, rep(6'd7), 16'h0000, 1, 1'b0};
        vecs[6] = '{"rb_ch3",   4'h4, 4'd3,  6'h00, rep(6'd7), 16'h0000, 1, 1'b0};

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_dac", DAC, d32);
        chk("rst_en", EN, 0);
        chk("rst_so", SO, 0);
        chk("rst_err", ERR, 0);
        chk("rst_done", DONE, 0);

        for (int v = 0; v < 7; v++) begin
            par_cmd(vecs[v].mode, vecs[v].addr, vecs[v].data);
            chk({vecs[v].name, "_dac"}, DAC, vecs[v].exp_dac);
            chk({vecs[v].name, "_en"}, EN, vecs[v].exp_en);
            chk({vecs[v].name, "_done"}, done_seen, vecs[v].exp_done);
            chk({vecs[v].name, "_err"}, ERR, vecs[v].exp_err);
            if (v == 0) chk("wr_ch5_latency", done_first <= 3, 1);
        end

        // Readback of ch3 after broadcast 7: {0011, 000111, 0}
        rbx = 11'b0011_000111_0;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) so_pulse();
            so_exp = (i <= 10) ? rbx[10 - i] : 1'b0;
            chk($sformatf("so_bit%0d", i), SO, so_exp);
        end

        send_bits({2'b00, 4'h3, 4'hA, 6'h01}, 14);
        strobe();
        chk("ser_en_en", EN, 16'h0400);
        chk("ser_en_done", done_seen, 1);
        chk("ser_en_dac", DAC, rep(6'd7));

        send_bits(16'h1ABC, 13);
        strobe();
        chk("short_err", ERR, 1);
        chk("short_done", done_seen, 0);
        chk("short_dac", DAC, rep(6'd7));
        chk("short_en", EN, 16'h0400);

        par_cmd(4'hF, 4'd0, 6'd0);
        chk("srst_err", ERR, 0);
        chk("srst_dac", DAC, d32);
        chk("srst_en", EN, 0);
        chk("srst_done", done_seen, 1);

        par_cmd(4'h7, 4'd1, 6'h05);
        chk("bad_err", ERR, 1);
        chk("bad_done", done_seen, 0);
        chk("bad_dac", DAC, d32);

        // Last SI_CLK rise coincides with STB rise at count 14
        send_bits({2'b00, 4'h1, 4'h9, 6'h15}, 14);
        done_seen  = 0;
        done_first = 0;
        @(negedge CLK);
        SI = 1'b1;
        SI_CLK = 1'b1;
        STB = 1'b1;
        watch(4);
        SI_CLK = 1'b0;
        watch(4);
        chk("simul_done", done_seen, 1);
        chk("simul_dac", DAC, with_ch(d32, 9, 6'h15));
        par_cmd(4'h1, 4'd0, 6'h01);
        chk("simul_cnt0_done", done_seen, 1);
        chk("simul_cnt0_dac", DAC, with_ch(with_ch(d32, 9, 6'h15), 0, 6'h01));

        send_bits(16'h002D, 6);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_dac", DAC, d32);
        chk("mid_rst_en", EN, 0);
        chk("mid_rst_err", ERR, 0);
        chk("mid_rst_so", SO, 0);
        par_cmd(4'h1, 4'd4, 6'h11);
        chk("post_rst_done", done_seen, 1);
        chk("post_rst_err", ERR, 0);
        chk("post_rst_dac", DAC, with_ch(d32, 4, 6'h11));

        send_bits(16'h0123, 15);
        strobe();
        chk("sat_err", ERR, 1);
        chk("sat_done", done_seen, 0);
        chk("sat_dac", DAC, with_ch(d32, 4, 6'h11));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
